// File: rtl/uart_axis_pkg.sv
// Shared defaults and FIFO entry layout for the UART-RX to AXI-Stream bridge.
package uart_axis_pkg;

   localparam int DEF_DATA_BITS    = 8;
   localparam int DEF_FIFO_DEPTH   = 16;
   // Two 10-bit frames at 9600 baud on a 100 MHz clock.
   localparam int DEF_IDLE_TIMEOUT = 208_320;

   // FIFO entry layout: tlast in the MSB, character below it.
   // The top module builds the same {tlast, data} layout at its own DATA_BITS.
   typedef struct packed {
      logic                     tlast;
      logic [DEF_DATA_BITS-1:0] data;
   } fifo_entry_t;

endpackage : uart_axis_pkg

// File: rtl/uart_rx_axis_bridge_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// A push is accepted when not full, or when a pop happens in the same cycle.
// The head entry is visible on data_o whenever count_o != 0; it reads 0 when empty.
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       accept_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q,  count_d;
   logic             do_pop;

   assign do_pop   = pop_i && (count_q != '0);
   assign accept_o = push_i && ((count_q != FULL_CNT) || do_pop);
   assign data_o   = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count_o  = count_q;

   // Next pointer and occupancy; power-of-two depth lets pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (accept_o) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (accept_o && !do_pop)      count_d = count_q + 1'b1;
      else if (!accept_o && do_pop) count_d = count_q - 1'b1;
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents after reset are don't-care because count is 0.
   always_ff @(posedge clk) begin
      if (!rst && accept_o) mem_q[wr_ptr_q] <= data_i;
   end

endmodule : sync_fifo

// File: rtl/uart_rx_axis_bridge.sv
// Bridges a UART receiver character strobe onto AXI-Stream.
// The newest character waits in a staging register until either another
// character arrives (it is sent with tlast=0) or the line stays idle for
// IDLE_TIMEOUT cycles (it is sent with tlast=1).
// Handshake: a beat transfers on a rising edge where m_axis_tvalid and
// m_axis_tready are both high; tdata/tlast hold steady while tvalid is high
// and tready is low, and tvalid never drops without a transfer.
module uart_rx_axis_bridge
   import uart_axis_pkg::*;
#(
   parameter int DATA_BITS    = DEF_DATA_BITS,
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
   parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_BITS-1:0]          rx_data,
   input  logic                          rx_valid,
   output logic [DATA_BITS-1:0]          m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          clr_overflow
);

   localparam int TW = $clog2(IDLE_TIMEOUT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(IDLE_TIMEOUT - 1);

   logic [DATA_BITS-1:0] stg_data_q, stg_data_d;
   logic                 stg_full_q, stg_full_d;
   logic [TW-1:0]        timer_q,    timer_d;
   logic                 overflow_q, overflow_d;

   logic                 timeout;
   logic                 push;
   logic                 push_ok;
   logic                 pop;
   logic [DATA_BITS:0]   push_entry;
   logic [DATA_BITS:0]   head_entry;

   // A new character always wins over a timeout landing in the same cycle.
   assign timeout    = stg_full_q && !rx_valid && (timer_q == TIMER_LAST);
   assign push       = (rx_valid && stg_full_q) || timeout;
   assign push_entry = {timeout, stg_data_q};
   assign pop        = m_axis_tvalid && m_axis_tready;

   // Staging register, idle timer and sticky overflow next-state.
   always_comb begin
      stg_data_d = stg_data_q;
      stg_full_d = stg_full_q;
      timer_d    = timer_q;
      overflow_d = overflow_q;
      if (rx_valid) begin
         stg_data_d = rx_data;
         stg_full_d = 1'b1;
         timer_d    = '0;
      end else if (timeout) begin
         stg_full_d = 1'b0;
         timer_d    = '0;
      end else if (stg_full_q) begin
         timer_d    = timer_q + 1'b1;
      end
      if (push && !push_ok)  overflow_d = 1'b1;
      else if (clr_overflow) overflow_d = 1'b0;
   end

   // Staging, timer and overflow registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stg_data_q <= '0;
         stg_full_q <= 1'b0;
         timer_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         stg_data_q <= stg_data_d;
         stg_full_q <= stg_full_d;
         timer_q    <= timer_d;
         overflow_q <= overflow_d;
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_i   (push),
      .data_i   (push_entry),
      .pop_i    (pop),
      .data_o   (head_entry),
      .count_o  (fifo_level),
      .accept_o (push_ok)
   );

   assign m_axis_tvalid = (fifo_level != '0);
   assign m_axis_tlast  = head_entry[DATA_BITS];
   assign m_axis_tdata  = head_entry[DATA_BITS-1:0];
   assign overflow      = overflow_q;

endmodule : uart_rx_axis_bridge

// File: tb/tb_uart_rx_axis_bridge.sv
// Directed bench for uart_rx_axis_bridge with a short idle timeout.
module tb_uart_rx_axis_bridge;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int IDLE  = 12;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic [LW-1:0] fifo_level;
   logic          overflow;
   logic          clr_overflow;

   int checks = 0;
   int errors = 0;
   int beats  = 0;
   int beats_mark;
   logic [DW:0] exp_q[$];
   logic [DW:0] mon_e;

   typedef struct {
      logic [DW-1:0] data;
      int            gap;    // cycles from this rx_valid to the next one
      logic          tlast;  // expected tlast of this character's beat
   } vec_t;
   vec_t vecs[8];

   uart_rx_axis_bridge #(
      .DATA_BITS    (DW),
      .FIFO_DEPTH   (DEPTH),
      .IDLE_TIMEOUT (IDLE)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .fifo_level    (fifo_level),
      .overflow      (overflow),
      .clr_overflow  (clr_overflow)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [DW-1:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   // One-character packet followed by enough silence for its timeout.
   task automatic send_packet(input logic [DW-1:0] b);
      send_byte(b);
      repeat (IDLE + 1) tick();
   endtask

   // Scoreboard: every transferred beat is compared with the expected queue.
   always @(negedge clk) begin
      if (!rst && m_axis_tvalid && m_axis_tready) begin
         beats++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got tlast=%0b data=0x%0h expected no beat",
                     m_axis_tlast, m_axis_tdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(mon_e));
         end
      end
   end

   initial begin
      vecs[0] = '{data: 8'h01, gap: 10,       tlast: 1'b0};
      vecs[1] = '{data: 8'h02, gap: 10,       tlast: 1'b0};
      vecs[2] = '{data: 8'h03, gap: IDLE + 4, tlast: 1'b1};
      vecs[3] = '{data: 8'h3C, gap: 1,        tlast: 1'b0};
      vecs[4] = '{data: 8'hC3, gap: 2,        tlast: 1'b0};
      vecs[5] = '{data: 8'h55, gap: IDLE,     tlast: 1'b0}; // next rx lands on the timeout cycle
      vecs[6] = '{data: 8'hAA, gap: IDLE + 1, tlast: 1'b1}; // first gap that times out
      vecs[7] = '{data: 8'h22, gap: IDLE + 4, tlast: 1'b1};

      rst           = 1'b1;
      rx_data       = '0;
      rx_valid      = 1'b0;
      m_axis_tready = 1'b0;
      clr_overflow  = 1'b0;
      repeat (2) tick();
      chk("rst_tvalid",   32'(m_axis_tvalid), 32'd0);
      chk("rst_level",    32'(fifo_level),    32'd0);
      chk("rst_overflow", 32'(overflow),      32'd0);
      chk("rst_tdata",    32'(m_axis_tdata),  32'd0);
      chk("rst_tlast",    32'(m_axis_tlast),  32'd0);
      rst = 1'b0;
      tick();

      // Single byte: beat appears exactly IDLE+1 cycles after its rx_valid.
      m_axis_tready = 1'b1;
      exp_q.push_back({1'b1, 8'hA5});
      send_byte(8'hA5);
      repeat (IDLE - 1) tick();
      chk("single_pre_valid", 32'(m_axis_tvalid), 32'd0);
      tick();
      chk("single_valid", 32'(m_axis_tvalid), 32'd1);
      chk("single_tlast", 32'(m_axis_tlast),  32'd1);
      chk("single_tdata", 32'(m_axis_tdata),  32'hA5);
      repeat (4) tick();

      // Burst table, including the timeout collision and the first timing-out gap.
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back({vecs[i].tlast, vecs[i].data});
         send_byte(vecs[i].data);
         if (vecs[i].tlast) begin
            repeat (IDLE - 1) tick();
            chk("vec_pre_valid", 32'(m_axis_tvalid), 32'd0);
            tick();
            chk("vec_valid", 32'(m_axis_tvalid), 32'd1);
            chk("vec_tlast", 32'(m_axis_tlast),  32'd1);
            chk("vec_tdata", 32'(m_axis_tdata),  32'(vecs[i].data));
            repeat (vecs[i].gap - IDLE - 1) tick();
         end else begin
            repeat (vecs[i].gap - 1) tick();
         end
      end
      repeat (4) tick();
      chk("burst_drained", 32'(exp_q.size()), 32'd0);

      // Backpressure and overflow: two extra packets are dropped.
      m_axis_tready = 1'b0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         if (i < DEPTH) exp_q.push_back({1'b1, 8'(8'h40 + i)});
         send_packet(8'(8'h40 + i));
      end
      chk("ovf_level",    32'(fifo_level),    32'(DEPTH));
      chk("ovf_flag",     32'(overflow),      32'd1);
      chk("ovf_valid",    32'(m_axis_tvalid), 32'd1);
      chk("ovf_head",     32'(m_axis_tdata),  32'h40);
      m_axis_tready = 1'b1;
      repeat (DEPTH + 4) tick();
      m_axis_tready = 1'b0;
      chk("ovf_drained",  32'(exp_q.size()),  32'd0);
      chk("ovf_level0",   32'(fifo_level),    32'd0);
      chk("ovf_sticky",   32'(overflow),      32'd1);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      chk("ovf_cleared",  32'(overflow),      32'd0);

      // Full FIFO: a push coinciding with a pop is accepted.
      for (int i = 0; i < DEPTH; i++) begin
         exp_q.push_back({1'b1, 8'(8'h80 + i)});
         send_packet(8'(8'h80 + i));
      end
      chk("full_level", 32'(fifo_level), 32'(DEPTH));
      exp_q.push_back({1'b1, 8'hEE});
      send_byte(8'hEE);
      repeat (IDLE - 1) tick();
      m_axis_tready = 1'b1;  // pop in the very cycle the timeout pushes EE
      tick();
      m_axis_tready = 1'b0;
      chk("full_pop_level",    32'(fifo_level),   32'(DEPTH));
      chk("full_pop_overflow", 32'(overflow),     32'd0);
      chk("full_pop_head",     32'(m_axis_tdata), 32'h81);
      m_axis_tready = 1'b1;
      repeat (DEPTH + 4) tick();
      m_axis_tready = 1'b0;
      chk("full_drained", 32'(exp_q.size()), 32'd0);

      // Mid-operation reset: three queued, one staged, all discarded.
      for (int i = 0; i < 3; i++) send_packet(8'(8'h90 + i));
      send_byte(8'h93);
      repeat (3) tick();
      chk("prerst_level", 32'(fifo_level), 32'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_tvalid",   32'(m_axis_tvalid), 32'd0);
      chk("midrst_level",    32'(fifo_level),    32'd0);
      chk("midrst_overflow", 32'(overflow),      32'd0);
      beats_mark    = beats;
      m_axis_tready = 1'b1;
      repeat (IDLE + 10) tick();
      chk("midrst_no_stale", 32'(beats - beats_mark), 32'd0);
      chk("midrst_level_end", 32'(fifo_level),         32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_uart_rx_axis_bridge

// File: doc/uart_rx_axis_bridge.md
UART_RX_AXIS_BRIDGE -- requirements
Module: uart_rx_axis_bridge

Interface
REQ-001 Parameter DATA_BITS, default 8, received character width; it SHALL match the receiver feeding this block.
REQ-002 Parameter FIFO_DEPTH, default 16, output FIFO entries; it SHALL be a power of two and at least 2.
REQ-003 Parameter IDLE_TIMEOUT, default 208_320, clk cycles of rx silence that end a packet (two 10-bit frames at 9600 baud on 100 MHz); it SHALL be at least 2.
REQ-004 Port clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port rx_data, input, DATA_BITS: received character, qualified by rx_valid.
REQ-007 Port rx_valid, input, 1: one-cycle strobe marking a new character.
REQ-008 Port m_axis_tdata, output, DATA_BITS: AXI-Stream data.
REQ-009 Port m_axis_tvalid, output, 1: AXI-Stream valid.
REQ-010 Port m_axis_tready, input, 1: AXI-Stream ready.
REQ-011 Port m_axis_tlast, output, 1: marks the final character before an idle gap.
REQ-012 Port fifo_level, output, clog2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-013 Port overflow, output, 1: sticky flag meaning a character was dropped.
REQ-014 Port clr_overflow, input, 1: clears overflow.

Function
REQ-015 Staging: a one-entry staging register (stg_data, stg_full) SHALL hold the newest character until its tlast value is known.
REQ-016 On rx_valid with stg_full=0: load rx_data, set stg_full, clear the idle timer; no FIFO push.
REQ-017 On rx_valid with stg_full=1: push {tlast=0, stg_data} into the FIFO and load rx_data in the same cycle; clear the idle timer.
REQ-018 Idle timer: while stg_full=1 and rx_valid=0, the timer increments by one each cycle.
REQ-019 Timeout: at timer==IDLE_TIMEOUT-1 with rx_valid=0, push {tlast=1, stg_data} and clear stg_full.
REQ-020 If rx_valid coincides with the timeout cycle, rx_valid wins: per REQ-017, the staged character is pushed with tlast=0.
REQ-021 FIFO write: a push SHALL be accepted when fifo_level<FIFO_DEPTH, or when a pop occurs in the same cycle.
REQ-022 FIFO full: a rejected push SHALL drop that character, set overflow, and leave FIFO contents unchanged; in the REQ-017 case, the new character is still loaded into staging.
REQ-023 Output: the FIFO SHALL be show-ahead; m_axis_tvalid=(fifo_level!=0); tdata and tlast SHALL come from the head entry.
REQ-024 Output data SHALL be stable while tvalid=1 and tready=0.
REQ-025 A pop SHALL occur exactly when tvalid and tready are both high.
REQ-026 Latency: a pushed entry SHALL reach the output one cycle after the push into an empty FIFO.
REQ-027 Latency: a lone character with rx_valid in cycle N SHALL give tvalid=1, tlast=1 in cycle N+IDLE_TIMEOUT+1.
REQ-028 fifo_level SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop; pointers wrap modulo FIFO_DEPTH.
REQ-029 overflow: set has priority over clr_overflow in the same cycle.

Reset
REQ-030 With rst high at a clock edge, the block SHALL clear stg_full, stg_data, the timer, the FIFO pointers, fifo_level, overflow, m_axis_tvalid, m_axis_tdata and m_axis_tlast to 0.
REQ-031 Characters staged or queued when reset hits SHALL be discarded; rx_valid and tready SHALL be ignored while rst=1.

Structure
REQ-032 Package uart_axis_pkg SHALL hold the default DATA_BITS, FIFO_DEPTH and IDLE_TIMEOUT, and the FIFO entry layout {tlast, data}.
REQ-033 The FIFO SHALL be one sub-module, sync_fifo (show-ahead, parameterised width/depth, count output); staging, timer and overflow logic SHALL stay in the top module.

Verification
REQ-034 Single byte: rx 0xA5, tready=1 -> one beat 0xA5 with tlast=1, tvalid high exactly at N+IDLE_TIMEOUT+1.
REQ-035 Burst: 0x01,0x02,0x03 spaced 10 cycles -> beats 01/02/03 with tlast=0,0,1; the 03 beat appears IDLE_TIMEOUT+1 cycles after its rx_valid.
REQ-036 Backpressure/overflow: tready=0, FIFO_DEPTH+2 packets of one byte -> fifo_level=16, overflow=1, the first 16 bytes delivered in order once tready=1; clr_overflow then -> overflow=0.
REQ-037 Timeout collision: rx_valid exactly on the timeout cycle -> the earlier byte is emitted with tlast=0 and the new byte later with tlast=1.
REQ-038 Full with simultaneous pop: FIFO full, tready=1, push in the same cycle -> push accepted, level stays 16, overflow stays 0.
REQ-039 Mid-operation reset: 3 bytes queued plus 1 staged, rst for 1 cycle -> tvalid=0, level=0, overflow=0, and no stale beat ever emitted.
